// File: rtl/mux_n_to_1_arb_if.sv
// -----------------------------------------------------------------------------
// mux_n_to_1_arb_if
//   Bundles the handshake and data signals of the N:1 registered multiplexer.
//   Input side:  in_data (NUM_INPUTS packed channels), in_valid, in_ready.
//   Output side: out_data, out_valid, out_ready, out_src (index of the
//                channel that produced out_data).
//   master : the environment (producers and sink) driving the multiplexer.
//   slave  : the multiplexer itself.
// -----------------------------------------------------------------------------
interface mux_n_to_1_arb_if #(
  parameter int WIDTH      = 32,
  parameter int NUM_INPUTS = 4
) ();
  localparam int SEL_W = $clog2(NUM_INPUTS);

  logic [NUM_INPUTS*WIDTH-1:0] in_data;
  logic [NUM_INPUTS-1:0]       in_valid;
  logic [NUM_INPUTS-1:0]       in_ready;
  logic [WIDTH-1:0]            out_data;
  logic                        out_valid;
  logic                        out_ready;
  logic [SEL_W-1:0]            out_src;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_src
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_src
  );
endinterface

// File: rtl/mux_n_to_1_arb.sv
// -----------------------------------------------------------------------------
// mux_n_to_1_arb
//   N-input, WIDTH-bit registered multiplexer with valid/ready on every input
//   and on the output. One output register stage: latency 1, throughput 1/cycle.
//   mode = 0 : channel chosen by sel (sel >= NUM_INPUTS grants nothing).
//   mode = 1 : round-robin over valid channels starting at rr_ptr.
// Ports
//   clk    : rising-edge clock
//   reset  : synchronous, active-high; clears output register and rr_ptr,
//            forces in_ready to zero
//   mode   : 0 = select, 1 = round-robin
//   sel    : channel index used in select mode
//   bus    : slave view of mux_n_to_1_arb_if (data, valid/ready, out_src)
// -----------------------------------------------------------------------------
module mux_n_to_1_arb #(
  parameter  int WIDTH      = 32,
  parameter  int NUM_INPUTS = 4,
  localparam int SEL_W      = $clog2(NUM_INPUTS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mode,
  input  logic [SEL_W-1:0] sel,
  mux_n_to_1_arb_if.slave  bus
);

  logic [WIDTH-1:0]      data_arr [NUM_INPUTS];
  logic [NUM_INPUTS-1:0] grant;
  logic                  grant_any;
  logic [SEL_W-1:0]      grant_idx;
  logic [WIDTH-1:0]      grant_data;
  logic                  load;

  logic [WIDTH-1:0]      out_data_reg;
  logic                  out_valid_reg;
  logic [SEL_W-1:0]      out_src_reg;
  logic [SEL_W-1:0]      rr_ptr_reg;
  logic [SEL_W-1:0]      rr_ptr_next;

  // The output register can accept a new word when empty or being drained.
  assign load = !out_valid_reg || bus.out_ready;

  generate
    for (genvar gi = 0; gi < NUM_INPUTS; gi++) begin : g_chan
      assign data_arr[gi]     = bus.in_data[gi*WIDTH +: WIDTH];
      assign grant[gi]        = grant_any && (grant_idx == SEL_W'(gi));
      assign bus.in_ready[gi] = load && grant[gi] && !reset;
    end
  endgenerate

  // Grant selection. In round-robin mode the candidate index is formed one
  // bit wider than SEL_W so that rr_ptr + k cannot overflow before the
  // modulo-N correction; this keeps non-power-of-two channel counts exact.
  always_comb begin : grant_logic
    logic [SEL_W:0] cand;
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = '0;
    if (mode) begin
      for (int k = 0; k < NUM_INPUTS; k++) begin
        cand = {1'b0, rr_ptr_reg} + (SEL_W+1)'(k);
        if (cand >= (SEL_W+1)'(NUM_INPUTS)) begin
          cand = cand - (SEL_W+1)'(NUM_INPUTS);
        end
        for (int i = 0; i < NUM_INPUTS; i++) begin
          if (!grant_any && (cand == (SEL_W+1)'(i)) && bus.in_valid[i]) begin
            grant_any = 1'b1;
            grant_idx = SEL_W'(i);
          end
        end
      end
    end else begin
      // Compare against every legal index so an out-of-range sel simply
      // matches nothing instead of indexing past the channel array.
      for (int i = 0; i < NUM_INPUTS; i++) begin
        if ((sel == SEL_W'(i)) && bus.in_valid[i]) begin
          grant_any = 1'b1;
          grant_idx = SEL_W'(i);
        end
      end
    end
  end

  // AND-OR data mux over the one-hot grant.
  always_comb begin
    grant_data = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (grant[i]) begin
        grant_data = grant_data | data_arr[i];
      end
    end
  end

  // Pointer advances past the winner, wrapping from NUM_INPUTS-1 to 0.
  assign rr_ptr_next = (grant_idx == SEL_W'(NUM_INPUTS-1)) ? '0
                                                           : grant_idx + SEL_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      out_data_reg  <= '0;
      out_valid_reg <= 1'b0;
      out_src_reg   <= '0;
      rr_ptr_reg    <= '0;
    end else if (load) begin
      if (grant_any) begin
        out_data_reg  <= grant_data;
        out_src_reg   <= grant_idx;
        out_valid_reg <= 1'b1;
        if (mode) begin
          rr_ptr_reg <= rr_ptr_next;
        end
      end else begin
        // Bubble: data and source index keep their last values.
        out_valid_reg <= 1'b0;
      end
    end
  end

  assign bus.out_data  = out_data_reg;
  assign bus.out_valid = out_valid_reg;
  assign bus.out_src   = out_src_reg;

endmodule
